riscv_dmem_arbiter: RTL and testbench

RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

---
 rtl/riscv_dmem_arbiter_if.sv | 17 +
 rtl/riscv_dmem_arbiter.sv | 117 +++++++++++
 tb/tb_riscv_dmem_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_arbiter_if.sv
// Data-memory bus bundle shared by the two requesting masters and the memory port.
// Masters drive the request fields and receive rd/ready/err.
interface riscv_dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;

  modport master (output req, we, be, addr, wd, input rd, ready, err);
  modport slave  (input req, we, be, addr, wd, output rd, ready, err);
  // Memory side has no error return; the arbiter generates timeouts itself.
  modport mem_master (output req, we, be, addr, wd, input rd, ready);
endinterface

// File: rtl/riscv_dmem_arbiter.sv
// Round-robin two-master data-memory arbiter with a per-grant timeout.
// One idle cycle separates transactions; the grant is chosen in IDLE.
module riscv_dmem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  riscv_dmem_arbiter_if.slave           m0,
  riscv_dmem_arbiter_if.slave           m1,
  riscv_dmem_arbiter_if.mem_master      mem,
  output logic [1:0]                    gnt_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;   // 1: m1 was served last
  logic [7:0] cnt_q, cnt_d;

  logic        sel1;
  logic        s_req, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wd;
  logic [31:0] r_rd;
  logic        r_ready, r_err;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    sel1   = (state_q == GNT1);
    s_req  = sel1 ? m1.req  : m0.req;
    s_we   = sel1 ? m1.we   : m0.we;
    s_be   = sel1 ? m1.be   : m0.be;
    s_addr = sel1 ? m1.addr : m0.addr;
    s_wd   = sel1 ? m1.wd   : m0.wd;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    mem.req    = 1'b0;
    mem.we     = 1'b0;
    mem.be     = '0;
    mem.addr   = '0;
    mem.wd     = '0;
    r_rd       = '0;
    r_ready    = 1'b0;
    r_err      = 1'b0;
    gnt_o      = 2'b00;
    busy_o     = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0.req && (!m1.req || last_gnt_q)) state_d = GNT0;
        else if (m1.req)                        state_d = GNT1;
      end
      GNT0, GNT1: begin
        gnt_o   = sel1 ? 2'b10 : 2'b01;
        mem.req = s_req;
        if (!s_req) begin
          // Master withdrew: release the bus silently.
          state_d    = IDLE;
          last_gnt_d = sel1;
        end else begin
          mem.we   = s_we;
          mem.be   = s_be;
          mem.addr = s_addr;
          mem.wd   = s_wd;
          r_rd     = mem.rd;
          r_ready  = mem.ready;
          if (mem.ready) begin
            state_d    = IDLE;
            last_gnt_d = sel1;
            cnt_d      = '0;
          end else if (cnt_q == TMO_LAST) begin
            r_rd       = '0;
            r_ready    = 1'b1;
            r_err      = 1'b1;
            state_d    = IDLE;
            last_gnt_d = sel1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0.rd    = sel1 ? '0   : r_rd;
    m0.ready = sel1 ? 1'b0 : r_ready;
    m0.err   = sel1 ? 1'b0 : r_err;
    m1.rd    = sel1 ? r_rd    : '0;
    m1.ready = sel1 ? r_ready : 1'b0;
    m1.err   = sel1 ? r_err   : 1'b0;
  end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Self-checking bench for riscv_dmem_arbiter: per-cycle vector table fed through
// an expected-value queue, plus a hand-written asynchronous-reset sequence.
module tb_riscv_dmem_arbiter;

  localparam logic [31:0] M0_ADDR = 32'h0000_0100;
  localparam logic [31:0] M0_WD   = 32'hDEAD_BEEF;
  localparam logic [3:0]  M0_BE   = 4'hF;
  localparam logic [31:0] M1_ADDR = 32'h0000_0200;
  localparam logic [31:0] M1_WD   = 32'hCAFE_F00D;
  localparam logic [3:0]  M1_BE   = 4'h3;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] gnt_o;
  logic       busy_o;

  riscv_dmem_arbiter_if m0_if ();
  riscv_dmem_arbiter_if m1_if ();
  riscv_dmem_arbiter_if mem_if ();

  riscv_dmem_arbiter #(.TIMEOUT(4)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .m0     (m0_if.slave),
    .m1     (m1_if.slave),
    .mem    (mem_if.mem_master),
    .gnt_o  (gnt_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        m0_req;
    logic        m0_we;
    logic        m1_req;
    logic        mem_ready;
    logic [31:0] mem_rd;
    logic [1:0]  gnt;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        m0_ready;
    logic        m0_err;
    logic [31:0] m0_rd;
    logic        m1_ready;
    logic        m1_err;
    logic [31:0] m1_rd;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t v(logic rst, logic m0r, logic m0we, logic m1r, logic mrdy,
                             logic [31:0] mrd, logic [1:0] gnt, logic mreq, logic [31:0] maddr,
                             logic r0, logic e0, logic [31:0] rd0,
                             logic r1, logic e1, logic [31:0] rd1);
    vec_t t;
    t.rst = rst; t.m0_req = m0r; t.m0_we = m0we; t.m1_req = m1r;
    t.mem_ready = mrdy; t.mem_rd = mrd; t.gnt = gnt; t.mem_req = mreq; t.mem_addr = maddr;
    t.m0_ready = r0; t.m0_err = e0; t.m0_rd = rd0;
    t.m1_ready = r1; t.m1_err = e1; t.m1_rd = rd1;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic clear_inputs();
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.be = M0_BE; m0_if.addr = M0_ADDR; m0_if.wd = M0_WD;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.be = M1_BE; m1_if.addr = M1_ADDR; m1_if.wd = M1_WD;
    mem_if.ready = 1'b0; mem_if.rd = '0; mem_if.err = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst.gnt", 32'(gnt_o), 32'h0);
    check("rst.busy", 32'(busy_o), 32'h0);
    check("rst.mem_req", 32'(mem_if.req), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic compare(input int i, input vec_t e);
    logic [31:0] x_wd;
    logic [3:0]  x_be;
    logic        x_we;
    x_wd = '0; x_be = '0; x_we = 1'b0;
    if (e.mem_addr == M0_ADDR) begin x_wd = M0_WD; x_be = M0_BE; x_we = m0_if.we; end
    if (e.mem_addr == M1_ADDR) begin x_wd = M1_WD; x_be = M1_BE; x_we = 1'b0; end
    check($sformatf("r%0d.gnt", i), 32'(gnt_o), 32'(e.gnt));
    check($sformatf("r%0d.busy", i), 32'(busy_o), 32'(e.gnt != 2'b00));
    check($sformatf("r%0d.mem_req", i), 32'(mem_if.req), 32'(e.mem_req));
    check($sformatf("r%0d.mem_addr", i), mem_if.addr, e.mem_addr);
    check($sformatf("r%0d.mem_wd", i), mem_if.wd, x_wd);
    check($sformatf("r%0d.mem_be", i), 32'(mem_if.be), 32'(x_be));
    check($sformatf("r%0d.mem_we", i), 32'(mem_if.we), 32'(x_we));
    check($sformatf("r%0d.m0_ready", i), 32'(m0_if.ready), 32'(e.m0_ready));
    check($sformatf("r%0d.m0_err", i), 32'(m0_if.err), 32'(e.m0_err));
    check($sformatf("r%0d.m0_rd", i), m0_if.rd, e.m0_rd);
    check($sformatf("r%0d.m1_ready", i), 32'(m1_if.ready), 32'(e.m1_ready));
    check($sformatf("r%0d.m1_err", i), 32'(m1_if.err), 32'(e.m1_err));
    check($sformatf("r%0d.m1_rd", i), m1_if.rd, e.m1_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // m0 write, memory ready two cycles after mem_req; stray ready while idle
    vecs.push_back(v(1, 1,1,0, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 1,1,0, 0,32'h0,         2'b01,1,M0_ADDR, 0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 1,1,0, 0,32'h0,         2'b01,1,M0_ADDR, 0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 1,1,0, 1,32'h55,        2'b01,1,M0_ADDR, 1,0,32'h55, 0,0,32'h0));
    vecs.push_back(v(0, 0,0,0, 1,32'h66,        2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    // Simultaneous requests after reset: m0, m1, m0 with idle bubbles
    vecs.push_back(v(1, 1,0,1, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 1,0,1, 1,32'h11,        2'b01,1,M0_ADDR, 1,0,32'h11, 0,0,32'h0));
    vecs.push_back(v(0, 1,0,1, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 1,0,1, 1,32'h22,        2'b10,1,M1_ADDR, 0,0,32'h0,  1,0,32'h22));
    vecs.push_back(v(0, 1,0,1, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 1,0,0, 1,32'h33,        2'b01,1,M0_ADDR, 1,0,32'h33, 0,0,32'h0));
    vecs.push_back(v(0, 0,0,0, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    // m1 read timeout (TIMEOUT=4), then ready landing in the 4th grant cycle
    vecs.push_back(v(1, 0,0,1, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 0,32'h0,         2'b10,1,M1_ADDR, 0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 0,32'h0,         2'b10,1,M1_ADDR, 0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 0,32'h0,         2'b10,1,M1_ADDR, 0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 0,32'hBAD,       2'b10,1,M1_ADDR, 0,0,32'h0,  1,1,32'h0));
    vecs.push_back(v(0, 0,0,0, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 0,32'h0,         2'b10,1,M1_ADDR, 0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 0,32'h77,        2'b10,1,M1_ADDR, 0,0,32'h0,  0,0,32'h77));
    vecs.push_back(v(0, 0,0,1, 0,32'h0,         2'b10,1,M1_ADDR, 0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 1,32'h12345678,  2'b10,1,M1_ADDR, 0,0,32'h0,  1,0,32'h12345678));
    vecs.push_back(v(0, 0,0,0, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    // m0 withdraws in its 2nd grant cycle; pending m1 follows after one idle cycle
    vecs.push_back(v(1, 1,0,1, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 1,0,1, 0,32'h0,         2'b01,1,M0_ADDR, 0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 1,32'h99,        2'b01,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 0,32'h0,         2'b00,0,32'h0,   0,0,32'h0,  0,0,32'h0));
    vecs.push_back(v(0, 0,0,1, 1,32'h44,        2'b10,1,M1_ADDR, 0,0,32'h0,  1,0,32'h44));

    clear_inputs();
    foreach (vecs[i]) begin
      vec_t e;
      if (vecs[i].rst) do_reset();
      @(posedge clk_i);
      #1;
      m0_if.req    = vecs[i].m0_req;
      m0_if.we     = vecs[i].m0_we;
      m1_if.req    = vecs[i].m1_req;
      mem_if.ready = vecs[i].mem_ready;
      mem_if.rd    = vecs[i].mem_rd;
      exp_q.push_back(vecs[i]);
      #3;
      if (exp_q.size() == 0) begin
        check($sformatf("r%0d.scoreboard", i), 32'(exp_q.size()), 32'h1);
      end else begin
        e = exp_q.pop_front();
        compare(i, e);
      end
    end

    // Asynchronous reset in the middle of a grant, then first grant after release
    do_reset();
    @(posedge clk_i);
    #1 m0_if.req = 1'b1;
    @(posedge clk_i);
    #3;
    check("arst.pre_mem_req", 32'(mem_if.req), 32'h1);
    check("arst.pre_gnt", 32'(gnt_o), 32'h1);
    rst_i = 1'b0;
    mem_if.ready = 1'b1;
    mem_if.rd = 32'hABCD;
    #1;
    check("arst.mem_req", 32'(mem_if.req), 32'h0);
    check("arst.gnt", 32'(gnt_o), 32'h0);
    check("arst.busy", 32'(busy_o), 32'h0);
    check("arst.m0_ready", 32'(m0_if.ready), 32'h0);
    check("arst.m0_rd", m0_if.rd, 32'h0);
    @(posedge clk_i);
    #1;
    mem_if.ready = 1'b0;
    m1_if.req = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #3;
    check("arst.first_gnt", 32'(gnt_o), 32'h1);
    check("arst.first_m0_ready", 32'(m0_if.ready), 32'h0);
    check("arst.m1_ready", 32'(m1_if.ready), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
